// File: rtl/cipher_pkg.sv
// Shared state encoding, defaults and helpers for the frame cipher sequencer.
// Kept separate so the line buffer and any future cipher wrappers agree on them.
package cipher_pkg;

  localparam int         DEPTH_DEFAULT     = 1024;
  localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h31;

  typedef logic [2:0] state_t;

  localparam state_t S_FILL = 3'd0;
  localparam state_t S_READ = 3'd1;
  localparam state_t S_ENC  = 3'd2;
  localparam state_t S_SEND = 3'd3;
  localparam state_t S_DONE = 3'd4;

  // Run length of consecutive terminator bytes; any other byte restarts it.
  function automatic logic [1:0] next_match(input logic [1:0] match, input logic is_term);
    return is_term ? match + 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Single-port line buffer: synchronous write, registered read.
// Write and read never coincide because the sequencer owns the port per state.
module line_buf_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/frame_cipher_ctrl.sv
// Sequencer between rxuart, one time-shared byte cipher and txuart.
// Buffers a line until three consecutive terminators, then streams the payload through the cipher.
module frame_cipher_ctrl
  import cipher_pkg::*;
#(
  parameter int         DEPTH     = DEPTH_DEFAULT,
  parameter int         AW        = $clog2(DEPTH),
  parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_rx_stb,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_err,
  input  logic [7:0]    i_key,
  input  logic [7:0]    i_offset,
  output logic          o_enc_req,
  output logic [7:0]    o_enc_data,
  output logic [7:0]    o_enc_key,
  output logic [7:0]    o_enc_offset,
  output logic [AW-1:0] o_enc_index,
  input  logic          i_enc_ack,
  input  logic [7:0]    i_enc_data,
  output logic          o_tx_stb,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy,
  output logic          o_busy,
  output logic          o_overflow,
  output logic          o_rx_drop
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] TWO  = (AW+1)'(2);

  state_t      state;
  logic [AW:0] count;
  logic [AW:0] idx;
  logic [AW:0] len;
  logic [1:0]  match;
  logic        overflow;
  logic [7:0]  key;
  logic [7:0]  offset;
  logic        enc_req;
  logic        tx_stb;
  logic [7:0]  tx_data;
  logic        rx_drop;

  logic          in_fill;
  logic          rx_ok;
  logic          is_term;
  logic          term_hit;
  logic [AW:0]   frame_len;
  logic [AW:0]   idx_next;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;

  assign in_fill  = (state == S_FILL);
  assign rx_ok    = i_rx_stb && !i_rx_err;
  assign is_term  = (i_rx_data == TERM_CHAR);
  assign term_hit = in_fill && rx_ok && is_term && (match == 2'd2);
  assign idx_next = idx + ONE;

  // Once overflowing, the terminator bytes never reached the buffer, so nothing is trimmed.
  assign frame_len = overflow ? count : count - TWO;

  assign ram_we   = in_fill && rx_ok && !term_hit && (count != FULL);
  assign ram_re   = (state == S_READ);
  assign ram_addr = in_fill ? count[AW-1:0] : idx[AW-1:0];

  line_buf_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_line_buf (
    .i_clk(i_clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(i_rx_data),
    .rdata(ram_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_FILL;
      count    <= '0;
      idx      <= '0;
      len      <= '0;
      match    <= 2'd0;
      overflow <= 1'b0;
      key      <= 8'h00;
      offset   <= 8'h00;
      enc_req  <= 1'b0;
      tx_stb   <= 1'b0;
      tx_data  <= 8'h00;
      rx_drop  <= 1'b0;
    end else begin
      rx_drop <= i_rx_stb && !in_fill;
      case (state)
        S_FILL: begin
          if (i_rx_stb && i_rx_err) begin
            match <= 2'd0;
          end else if (term_hit) begin
            len    <= frame_len;
            key    <= i_key;
            offset <= i_offset;
            idx    <= '0;
            state  <= (frame_len == '0) ? S_DONE : S_READ;
          end else if (rx_ok) begin
            match <= next_match(match, is_term);
            if (count != FULL) begin
              count <= count + ONE;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        S_READ: begin
          enc_req <= 1'b1;
          state   <= S_ENC;
        end
        S_ENC: begin
          if (i_enc_ack) begin
            tx_data <= i_enc_data;
            enc_req <= 1'b0;
            tx_stb  <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_stb && !i_tx_busy) begin
            tx_stb <= 1'b0;
            idx    <= idx_next;
            state  <= (idx_next == len) ? S_DONE : S_READ;
          end
        end
        S_DONE: begin
          count    <= '0;
          match    <= 2'd0;
          overflow <= 1'b0;
          state    <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // RAM output is only meaningful while a request is pending; keep the bus quiet otherwise.
  assign o_enc_req    = enc_req;
  assign o_enc_data   = enc_req ? ram_rdata : 8'h00;
  assign o_enc_key    = key;
  assign o_enc_offset = offset;
  assign o_enc_index  = idx[AW-1:0];
  assign o_tx_stb     = tx_stb;
  assign o_tx_data    = tx_data;
  assign o_busy       = !in_fill;
  assign o_overflow   = overflow;
  assign o_rx_drop    = rx_drop;

endmodule
